serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_cell.sv | 21 ++
 rtl/serial_subtractor.sv | 112 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor built from two half-subtractor stages plus OR.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  // First half-subtractor x - y, second subtracts the incoming borrow.
  assign d1   = x ^ y;
  assign b1   = ~x & y;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor (diff = a - b) with valid/ready on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;
  logic             release_out;

  full_subtractor_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    last_bit    = 1'b0;
    release_out = 1'b0;
    unique case (state)
      IDLE: begin
        accept = in_valid;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        last_bit = (cnt == LAST);
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        release_out = out_valid && out_ready;
        if (out_valid && out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // res keeps only WIDTH-1 bits: the final digit is merged straight into diff.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      borrow     <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        borrow <= 1'b0;
        cnt    <= '0;
      end
      if (state == SHIFT) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res    <= (WIDTH-1)'({cell_d, res} >> 1);
        borrow <= cell_bout;
        if (!last_bit) cnt <= cnt + CW'(1);
      end
      if (last_bit) begin
        diff       <= {cell_d, res};
        borrow_out <= cell_bout;
        out_valid  <= 1'b1;
      end
      if (release_out) out_valid <= 1'b0;
    end
  end

endmodule
